// File: rtl/oled_refresh.sv
// Streams the 1024x8 display RAM to an SSD1306-class OLED over 4-wire SPI (mode 0).
// Each page is sent as three command bytes followed by 128 column bytes. Frames repeat while en_ram_rd stays high.
module oled_refresh #(
  parameter int CLK_DIV    = 2,
  parameter int COL_OFFSET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_ram_rd,
  output logic [9:0] rdaddress,
  input  logic [7:0] q,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] COL_LO   = 8'(COL_OFFSET % 16);
  localparam logic [7:0] COL_HI   = 8'h10 | 8'((COL_OFFSET / 16) % 16);

  logic [2:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] div_cnt_reg;
  logic [6:0] col_reg;
  logic [2:0] page_reg;
  logic [1:0] cmd_idx_reg;
  logic       fetch_wait_reg;
  logic [6:0] shift_reg;
  logic [7:0] cmd_byte;

  always_comb begin
    cmd_byte = 8'hB0 | {5'd0, page_reg};
    if (cmd_idx_reg == 2'd1) begin
      cmd_byte = COL_LO;
    end else if (cmd_idx_reg == 2'd2) begin
      cmd_byte = COL_HI;
    end
  end

  // oled_dc is switched at the end of GAP, so it always settles while chip select is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= 3'd0;
      div_cnt_reg    <= 8'd0;
      col_reg        <= 7'd0;
      page_reg       <= 3'd0;
      cmd_idx_reg    <= 2'd0;
      fetch_wait_reg <= 1'b0;
      shift_reg      <= 7'd0;
      rdaddress      <= 10'd0;
      oled_cs_n      <= 1'b1;
      oled_dc        <= 1'b0;
      oled_sclk      <= 1'b0;
      oled_mosi      <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (en_ram_rd) begin
            state_reg   <= S_CMD;
            busy        <= 1'b1;
            page_reg    <= 3'd0;
            col_reg     <= 7'd0;
            cmd_idx_reg <= 2'd0;
            oled_dc     <= 1'b0;
          end
        end
        S_CMD: begin
          shift_reg   <= cmd_byte[6:0];
          oled_mosi   <= cmd_byte[7];
          oled_cs_n   <= 1'b0;
          bit_cnt_reg <= 3'd0;
          div_cnt_reg <= 8'd0;
          state_reg   <= S_SHIFT;
        end
        S_FETCH: begin
          // rdaddress was set on entry; q is valid in the second FETCH cycle.
          if (!fetch_wait_reg) begin
            fetch_wait_reg <= 1'b1;
          end else begin
            fetch_wait_reg <= 1'b0;
            shift_reg      <= q[6:0];
            oled_mosi      <= q[7];
            oled_cs_n      <= 1'b0;
            bit_cnt_reg    <= 3'd0;
            div_cnt_reg    <= 8'd0;
            state_reg      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= 8'd0;
            if (!oled_sclk) begin
              oled_sclk <= 1'b1;
            end else begin
              oled_sclk <= 1'b0;
              if (bit_cnt_reg == 3'd7) begin
                oled_cs_n <= 1'b1;
                state_reg <= S_GAP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                oled_mosi   <= shift_reg[6];
                shift_reg   <= {shift_reg[5:0], 1'b0};
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end
        S_GAP: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= 8'd0;
            if (!oled_dc) begin
              if (cmd_idx_reg != 2'd2) begin
                cmd_idx_reg <= cmd_idx_reg + 2'd1;
                state_reg   <= S_CMD;
              end else begin
                cmd_idx_reg <= 2'd0;
                oled_dc     <= 1'b1;
                rdaddress   <= {~page_reg, col_reg};
                state_reg   <= S_FETCH;
              end
            end else if (col_reg != 7'd127) begin
              col_reg   <= col_reg + 7'd1;
              rdaddress <= {~page_reg, col_reg + 7'd1};
              state_reg <= S_FETCH;
            end else if (page_reg != 3'd7) begin
              col_reg   <= 7'd0;
              page_reg  <= page_reg + 3'd1;
              oled_dc   <= 1'b0;
              state_reg <= S_CMD;
            end else begin
              col_reg    <= 7'd0;
              page_reg   <= 3'd0;
              oled_dc    <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state_reg  <= S_DONE;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_refresh.sv
// Bench for oled_refresh: three instances (CLK_DIV 2 / 3 / 1, COL_OFFSET 2 on the last).
// Each instance has its own RAM and SPI monitor. A frame-order reference model predicts every byte.
module tb_oled_refresh;

  localparam int FRAME = 1048;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   sf_base = 0;
  int   cr_base = 0;
  logic [7:0] mem [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DIV = (gi == 0) ? 2 : ((gi == 1) ? 3 : 1);
    localparam int OFF = (gi == 2) ? 2 : 0;
    logic       en;
    logic [9:0] rdaddress;
    logic [7:0] q;
    logic       cs_n, dc, sclk, mosi, busy, frame_done;
    logic [8:0] cap [$];
    int nbits [$];
    int start_q [$];
    int gap_q [$];
    int fd_cyc [$];
    int fd_count = 0;
    int v_phase = 0, v_mosi = 0, v_dc = 0, v_cs = 0, v_fd = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_busy = 1'b0;
    logic [7:0] sh = 8'h00;
    int nb = 0, lo = 0, hi = 0, cs_hi = 0;

    oled_refresh #(.CLK_DIV(DIV), .COL_OFFSET(OFF)) u_dut (
      .clk(clk), .rst_n(rst_n), .en_ram_rd(en), .rdaddress(rdaddress), .q(q),
      .oled_cs_n(cs_n), .oled_dc(dc), .oled_sclk(sclk), .oled_mosi(mosi),
      .busy(busy), .frame_done(frame_done));

    always @(posedge clk) q <= mem[gi][rdaddress];

    // SPI monitor, sampled on the falling clk edge, away from the DUT's update edge.
    always @(negedge clk) begin
      if (rst_n) begin
        if (!cs_n && !busy) v_cs++;
        if (sclk && cs_n) v_cs++;
        if ((dc != p_dc) && (!cs_n || !p_cs)) v_dc++;
        if (!cs_n) begin
          if (p_cs) begin
            nb = 0; lo = 0; hi = 0;
            start_q.push_back(cyc);
            gap_q.push_back(cs_hi);
          end
          if ((mosi != p_mosi) && !p_cs && !(p_sclk && !sclk)) v_mosi++;
          if (sclk) begin
            if (!p_sclk) begin
              if (lo != DIV) v_phase++;
              sh = {sh[6:0], mosi};
              nb++;
              hi = 0;
            end
            hi++;
          end else begin
            if (p_sclk) begin
              if (hi != DIV) v_phase++;
              lo = 0;
            end
            lo++;
          end
        end else begin
          if (!p_cs) begin
            if (!p_sclk || hi != DIV) v_phase++;
            cap.push_back({p_dc, sh});
            nbits.push_back(nb);
            cs_hi = 0;
          end
          cs_hi++;
        end
        if (frame_done) begin
          fd_count++;
          fd_cyc.push_back(cyc);
          if (busy || !p_busy) v_fd++;
        end
      end else begin
        nb = 0; lo = 0; hi = 0; cs_hi = 0;
      end
      p_cs = cs_n; p_sclk = sclk; p_mosi = mosi; p_dc = dc; p_busy = busy;
    end
  end

  // Reference: byte i of a frame, {dc, value}, straight from the page/column frame order.
  function automatic logic [8:0] exp_byte(input int inst, input int off, input int i);
    int p, j;
    p = (i % FRAME) / 131;
    j = (i % FRAME) % 131;
    if (j == 0) return {1'b0, 8'hB0 + 8'(p)};
    if (j == 1) return {1'b0, 4'h0, off[3:0]};
    if (j == 2) return {1'b0, 4'h1, off[7:4]};
    return {1'b1, mem[inst][(7 - p) * 128 + j - 3]};
  endfunction

  function automatic logic [9:0] cap_at(input int inst, input int idx);
    case (inst)
      0: if (idx < g_dut[0].cap.size()) return {1'b1, g_dut[0].cap[idx]};
      1: if (idx < g_dut[1].cap.size()) return {1'b1, g_dut[1].cap[idx]};
      default: if (idx < g_dut[2].cap.size()) return {1'b1, g_dut[2].cap[idx]};
    endcase
    return 10'h000;
  endfunction

  task automatic test_reset();
    int n, bad;
    checks++;
    if ({g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].mosi, g_dut[0].dc, g_dut[0].busy, g_dut[0].frame_done,
         g_dut[1].cs_n, g_dut[2].cs_n, g_dut[1].busy, g_dut[2].busy} !== 10'b1000001100) begin
      failures++;
      $display("FAIL reset_idle: cs/sclk/mosi/dc/busy/fd + cs1 cs2 busy1 busy2 = %b, required 1000001100",
               {g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].mosi, g_dut[0].dc, g_dut[0].busy, g_dut[0].frame_done,
                g_dut[1].cs_n, g_dut[2].cs_n, g_dut[1].busy, g_dut[2].busy});
    end
    @(negedge clk); g_dut[0].en = 1'b1;
    @(negedge clk); g_dut[0].en = 1'b0;
    n = 0;
    while (!(g_dut[0].cs_n == 1'b0 && g_dut[0].dc == 1'b1) && n < 2000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL reset_reach_data: no data byte after %0d clk, required one within 2000", n);
    end
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].mosi, g_dut[0].dc, g_dut[0].busy, g_dut[0].frame_done} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_mid_byte: cs_n/sclk/mosi/dc/busy/fd = %b, required 100000",
               {g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].mosi, g_dut[0].dc, g_dut[0].busy, g_dut[0].frame_done});
    end
    checks++;
    if (g_dut[0].rdaddress !== 10'd0) begin
      failures++;
      $display("FAIL reset_rdaddress: got %0d, required 0", g_dut[0].rdaddress);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (g_dut[0].cs_n !== 1'b1 || g_dut[0].busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_after_reset: %0d cycles with cs_n low or busy high, required 0", bad);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_frame();
    int c0, f0, vp, vm, vd, vc, vf, n, bad, first;
    c0 = g_dut[0].cap.size(); f0 = g_dut[0].fd_count;
    vp = g_dut[0].v_phase; vm = g_dut[0].v_mosi; vd = g_dut[0].v_dc; vc = g_dut[0].v_cs; vf = g_dut[0].v_fd;
    sf_base = c0;
    @(negedge clk); g_dut[0].en = 1'b1;
    @(negedge clk); g_dut[0].en = 1'b0;
    n = 0;
    while (g_dut[0].fd_count == f0 && n < 45000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 45000) begin failures++; $display("FAIL frame_timeout: no frame_done in %0d clk", n); end
    repeat (20) @(negedge clk);
    checks++;
    if (g_dut[0].cap.size() - c0 != FRAME) begin
      failures++;
      $display("FAIL frame_byte_count: got %0d, required %0d", g_dut[0].cap.size() - c0, FRAME);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_at(0, c0 + i) !== {1'b1, exp_byte(0, 0, i)}) begin
        failures++;
        $display("FAIL first_bytes[%0d]: got %h, required %h", i, cap_at(0, c0 + i), {1'b1, exp_byte(0, 0, i)});
      end
    end
    checks++;
    if (cap_at(0, c0 + 7 * 131 + 3) !== {1'b1, exp_byte(0, 0, 7 * 131 + 3)}) begin
      failures++;
      $display("FAIL page7_first_data: got %h, required %h", cap_at(0, c0 + 7 * 131 + 3), {1'b1, exp_byte(0, 0, 7 * 131 + 3)});
    end
    bad = 0; first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (cap_at(0, c0 + i) !== {1'b1, exp_byte(0, 0, i)}) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frame_content: %0d wrong bytes (first at %0d), required 0", bad, first);
    end
    checks++;
    if (g_dut[0].fd_count - f0 != 1 || g_dut[0].busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_once: pulses %0d busy %b, required 1 pulse and busy 0", g_dut[0].fd_count - f0, g_dut[0].busy);
    end
    checks++;
    if (g_dut[0].v_phase != vp || g_dut[0].v_mosi != vm || g_dut[0].v_dc != vd || g_dut[0].v_cs != vc || g_dut[0].v_fd != vf) begin
      failures++;
      $display("FAIL frame_protocol: phase %0d mosi %0d dc %0d cs %0d fd %0d violations, required all 0",
               g_dut[0].v_phase - vp, g_dut[0].v_mosi - vm, g_dut[0].v_dc - vd, g_dut[0].v_cs - vc, g_dut[0].v_fd - vf);
    end
    $display("test_single_frame: %0d bytes captured", g_dut[0].cap.size() - c0);
  endtask

  task automatic test_continuous();
    int c0, s0, f0, vf, n, bad, first, lat;
    for (int a = 0; a < 1024; a++) mem[2][a] = 8'($urandom);
    c0 = g_dut[2].cap.size(); s0 = g_dut[2].start_q.size(); f0 = g_dut[2].fd_count; vf = g_dut[2].v_fd;
    cr_base = c0;
    @(negedge clk); g_dut[2].en = 1'b1;
    n = 0;
    while (g_dut[2].fd_count < f0 + 1 && n < 25000) begin @(negedge clk); n++; end
    repeat (2000) @(negedge clk);
    g_dut[2].en = 1'b0;
    while (g_dut[2].fd_count < f0 + 2 && n < 50000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50000) begin failures++; $display("FAIL cont_timeout: frames done %0d, required 2", g_dut[2].fd_count - f0); end
    repeat (200) @(negedge clk);
    checks++;
    if (g_dut[2].cap.size() - c0 != 2 * FRAME || g_dut[2].fd_count - f0 != 2) begin
      failures++;
      $display("FAIL cont_two_frames: bytes %0d pulses %0d, required %0d and 2",
               g_dut[2].cap.size() - c0, g_dut[2].fd_count - f0, 2 * FRAME);
    end
    bad = 0; first = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cap_at(2, c0 + i) !== {1'b1, exp_byte(2, 2, i)}) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cont_content: %0d wrong bytes (first at %0d), required 0", bad, first);
    end
    lat = -1;
    if (g_dut[2].start_q.size() > s0 + FRAME && g_dut[2].fd_cyc.size() > f0)
      lat = g_dut[2].start_q[s0 + FRAME] - g_dut[2].fd_cyc[f0];
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL cont_restart_latency: cs_n fell %0d clk after frame_done, required 3", lat);
    end
    checks++;
    if (g_dut[2].busy !== 1'b0 || g_dut[2].cs_n !== 1'b1 || g_dut[2].v_fd != vf) begin
      failures++;
      $display("FAIL cont_idle_end: busy %b cs_n %b fd_violations %0d, required 0 1 0",
               g_dut[2].busy, g_dut[2].cs_n, g_dut[2].v_fd - vf);
    end
    $display("test_continuous: %0d bytes captured", g_dut[2].cap.size() - c0);
  endtask

  task automatic test_spi_timing();
    int c0, s0, vp, vm, vd, vc, n, bad, bad_bits, bad_bytes;
    for (int a = 0; a < 1024; a++) mem[1][a] = 8'($urandom);
    c0 = g_dut[1].cap.size(); s0 = g_dut[1].gap_q.size();
    vp = g_dut[1].v_phase; vm = g_dut[1].v_mosi; vd = g_dut[1].v_dc; vc = g_dut[1].v_cs;
    @(negedge clk); g_dut[1].en = 1'b1;
    @(negedge clk); g_dut[1].en = 1'b0;
    n = 0;
    while (g_dut[1].cap.size() - c0 < 140 && n < 12000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 12000) begin failures++; $display("FAIL spi_timeout: %0d bytes, required 140", g_dut[1].cap.size() - c0); end
    checks++;
    if (g_dut[1].v_phase != vp) begin
      failures++; $display("FAIL spi_sclk_phase: %0d phases not 3 clk, required 0", g_dut[1].v_phase - vp);
    end
    checks++;
    if (g_dut[1].v_mosi != vm) begin
      failures++; $display("FAIL spi_mosi_stable: %0d changes off SCLK fall, required 0", g_dut[1].v_mosi - vm);
    end
    checks++;
    if (g_dut[1].v_dc != vd || g_dut[1].v_cs != vc) begin
      failures++;
      $display("FAIL spi_dc_cs: dc %0d cs %0d violations, required 0 0", g_dut[1].v_dc - vd, g_dut[1].v_cs - vc);
    end
    // cs_n high between bytes: GAP of CLK_DIV clk plus 1 load clk (command) or 2 (fetch + latch).
    bad = 0; bad_bits = 0; bad_bytes = 0;
    for (int i = 1; i < 140; i++) begin
      if (g_dut[1].gap_q.size() <= s0 + i || g_dut[1].gap_q[s0 + i] != 3 + (((i % 131) >= 3) ? 2 : 1)) bad++;
    end
    for (int i = 0; i < 140; i++) begin
      if (g_dut[1].nbits.size() <= c0 + i || g_dut[1].nbits[c0 + i] != 8) bad_bits++;
      if (cap_at(1, c0 + i) !== {1'b1, exp_byte(1, 0, i)}) bad_bytes++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL spi_cs_gap: %0d gaps wrong length, required 0", bad); end
    checks++;
    if (bad_bits != 0) begin failures++; $display("FAIL spi_bits_per_byte: %0d bytes not 8 bits, required 0", bad_bits); end
    checks++;
    if (bad_bytes != 0) begin failures++; $display("FAIL spi_bytes: %0d wrong bytes, required 0", bad_bytes); end
    $display("test_spi_timing: %0d bytes inspected", 140);
  endtask

  task automatic test_page_boundary();
    for (int i = 128; i < 136; i++) begin
      checks++;
      if (cap_at(0, sf_base + i) !== {1'b1, exp_byte(0, 0, i)}) begin
        failures++;
        $display("FAIL page_boundary_seq[%0d]: got %h, required %h", i, cap_at(0, sf_base + i), {1'b1, exp_byte(0, 0, i)});
      end
    end
    for (int p = 1; p < 8; p++) begin
      checks++;
      if (cap_at(2, cr_base + p * 131 - 1) !== {1'b1, exp_byte(2, 2, p * 131 - 1)} ||
          cap_at(2, cr_base + p * 131 + 3) !== {1'b1, exp_byte(2, 2, p * 131 + 3)}) begin
        failures++;
        $display("FAIL page_boundary_rand[%0d]: got %h %h, required %h %h", p,
                 cap_at(2, cr_base + p * 131 - 1), cap_at(2, cr_base + p * 131 + 3),
                 {1'b1, exp_byte(2, 2, p * 131 - 1)}, {1'b1, exp_byte(2, 2, p * 131 + 3)});
      end
    end
    $display("test_page_boundary: done");
  endtask

  task automatic test_col_offset();
    logic [29:0] got, req;
    logic [7:0]  b0;
    for (int p = 0; p < 8; p++) begin
      b0  = 8'hB0 + 8'(p);
      got = {cap_at(2, cr_base + p * 131), cap_at(2, cr_base + p * 131 + 1), cap_at(2, cr_base + p * 131 + 2)};
      req = {2'b10, b0, 2'b10, 8'h02, 2'b10, 8'h10};
      checks++;
      if (got !== req) begin
        failures++;
        $display("FAIL col_offset_page%0d: got %h, required %h", p, got, req);
      end
    end
    $display("test_col_offset: done");
  endtask

  initial begin
    rst_n = 1'b0;
    g_dut[0].en = 1'b0;
    g_dut[1].en = 1'b0;
    g_dut[2].en = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      mem[0][a] = 8'(a);
      mem[1][a] = 8'h00;
      mem[2][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    fork
      test_single_frame();
      test_continuous();
      test_spi_timing();
    join
    test_page_boundary();
    test_col_offset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
